// File: rtl/serial_pattern_detector.sv
// Serial pattern detector: sliding window over accepted bits, registered match pulse
// and a saturating match counter.
module serial_pattern_detector #(
   parameter int unsigned                 PATTERN_W = 4,
   parameter logic [PATTERN_W-1:0]        PATTERN   = 4'b1011,
   parameter int unsigned                 COUNT_W   = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 bit_in,
   input  logic                 bit_valid,
   input  logic                 clear,
   output logic [PATTERN_W-1:0] window,
   output logic                 window_valid,
   output logic                 match,
   output logic [COUNT_W-1:0]   match_count,
   output logic                 count_sat
);

   localparam int unsigned     FILL_W = $clog2(PATTERN_W + 1);
   localparam logic [FILL_W-1:0] FULL = FILL_W'(PATTERN_W);

   logic [PATTERN_W-1:0] window_q, window_d;
   logic [FILL_W-1:0]    fill_q, fill_d;
   logic [COUNT_W-1:0]   count_q, count_d;
   logic                 match_q, match_d;
   logic                 sat_q, sat_d;
   logic                 valid_q, valid_d;
   logic [PATTERN_W-1:0] next_window;
   logic                 hit;

   always_comb begin
      next_window = {window_q[PATTERN_W-2:0], bit_in};
      // Fill qualifier keeps the zero prefill from matching patterns with leading zeros
      hit         = (next_window == PATTERN) && (fill_q >= FULL - FILL_W'(1));
      window_d    = window_q;
      fill_d      = fill_q;
      count_d     = count_q;
      match_d     = 1'b0;
      if (clear) begin
         window_d = '0;
         fill_d   = '0;
         count_d  = '0;
      end else if (bit_valid) begin
         window_d = next_window;
         if (fill_q != FULL) begin
            fill_d = fill_q + FILL_W'(1);
         end
         if (hit) begin
            match_d = 1'b1;
            if (count_q != '1) begin
               count_d = count_q + COUNT_W'(1);
            end
         end
      end
      sat_d   = (count_d == '1);
      valid_d = (fill_d == FULL);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         window_q <= '0;
         fill_q   <= '0;
         count_q  <= '0;
         match_q  <= 1'b0;
         sat_q    <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         window_q <= window_d;
         fill_q   <= fill_d;
         count_q  <= count_d;
         match_q  <= match_d;
         sat_q    <= sat_d;
         valid_q  <= valid_d;
      end
   end

   assign window       = window_q;
   assign window_valid = valid_q;
   assign match        = match_q;
   assign match_count  = count_q;
   assign count_sat    = sat_q;

endmodule

// File: tb/tb_serial_pattern_detector.sv
// Bench for serial_pattern_detector: three parameterisations share one stimulus stream and
// are checked each cycle against a history-based model, plus literal directed checks.
module tb_serial_pattern_detector;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic bit_in = 1'b0;
   logic bit_valid = 1'b0;
   logic clear = 1'b0;

   logic [3:0] win_o [3];
   logic       wv_o  [3];
   logic       mt_o  [3];
   logic [7:0] cnt_o [3];
   logic       sat_o [3];
   logic [1:0] cnt2;

   int checks = 0;
   int errors = 0;

   // Model state: accepted bits since reset/clear, last four as an integer, hits, last pulse
   int acc [3];
   int mwin [3];
   int mcnt [3];
   int mmatch [3];
   int pat [3]  = '{11, 1, 15};
   int cmax [3] = '{255, 255, 3};

   always #5 clk = ~clk;

   serial_pattern_detector #(.PATTERN_W(4), .PATTERN(4'b1011), .COUNT_W(8)) u0 (
      .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .clear(clear),
      .window(win_o[0]), .window_valid(wv_o[0]), .match(mt_o[0]),
      .match_count(cnt_o[0]), .count_sat(sat_o[0]));

   serial_pattern_detector #(.PATTERN_W(4), .PATTERN(4'b0001), .COUNT_W(8)) u1 (
      .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .clear(clear),
      .window(win_o[1]), .window_valid(wv_o[1]), .match(mt_o[1]),
      .match_count(cnt_o[1]), .count_sat(sat_o[1]));

   serial_pattern_detector #(.PATTERN_W(4), .PATTERN(4'b1111), .COUNT_W(2)) u2 (
      .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .clear(clear),
      .window(win_o[2]), .window_valid(wv_o[2]), .match(mt_o[2]),
      .match_count(cnt2), .count_sat(sat_o[2]));

   assign cnt_o[2] = {6'b0, cnt2};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk or negedge rst) begin
      for (int i = 0; i < 3; i++) begin
         if (!rst || clear) begin
            acc[i] = 0; mwin[i] = 0; mcnt[i] = 0; mmatch[i] = 0;
         end else if (bit_valid) begin
            mwin[i]   = ((mwin[i] * 2) + int'(bit_in)) % 16;
            acc[i]    = acc[i] + 1;
            mmatch[i] = (acc[i] >= 4 && mwin[i] == pat[i]) ? 1 : 0;
            if (mmatch[i] == 1 && mcnt[i] < cmax[i]) mcnt[i] = mcnt[i] + 1;
         end else begin
            mmatch[i] = 0;
         end
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("u%0d window", i), 32'(win_o[i]), mwin[i]);
         chk($sformatf("u%0d window_valid", i), 32'(wv_o[i]), (acc[i] >= 4) ? 1 : 0);
         chk($sformatf("u%0d match", i), 32'(mt_o[i]), mmatch[i]);
         chk($sformatf("u%0d match_count", i), 32'(cnt_o[i]), mcnt[i]);
         chk($sformatf("u%0d count_sat", i), 32'(sat_o[i]), (mcnt[i] == cmax[i]) ? 1 : 0);
      end
   end

   task automatic drive(input logic v, input logic b, input logic c);
      @(negedge clk);
      bit_valid = v;
      bit_in    = b;
      clear     = c;
   endtask

   task automatic send(input logic b);
      drive(1'b1, b, 1'b0);
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0);
   endtask

   task automatic async_reset();
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("u%0d async window", i), 32'(win_o[i]), 0);
         chk($sformatf("u%0d async match", i), 32'(mt_o[i]), 0);
         chk($sformatf("u%0d async count", i), 32'(cnt_o[i]), 0);
         chk($sformatf("u%0d async valid", i), 32'(wv_o[i]), 0);
         chk($sformatf("u%0d async sat", i), 32'(sat_o[i]), 0);
      end
      @(negedge clk);
      rst = 1'b1;
      bit_valid = 1'b0;
      clear = 1'b0;
   endtask

   initial begin
      @(negedge clk);
      chk("reset window", 32'(win_o[0]), 0);
      chk("reset count", 32'(cnt_o[0]), 0);
      rst = 1'b1;

      // Fill qualifier on 0001 plus basic hit and overlap with a gap on 1011
      send(1'b1);
      idle();
      chk("u1 single-bit window", 32'(win_o[1]), 4'b0001);
      chk("u1 single-bit match", 32'(mt_o[1]), 0);
      chk("u1 single-bit valid", 32'(wv_o[1]), 0);
      send(1'b0); send(1'b1); idle(); idle();
      send(1'b1);
      idle();
      chk("u0 first hit match", 32'(mt_o[0]), 1);
      chk("u0 first hit count", 32'(cnt_o[0]), 1);
      chk("u0 first hit window", 32'(win_o[0]), 4'b1011);
      chk("u0 first hit valid", 32'(wv_o[0]), 1);
      idle();
      chk("u0 pulse width", 32'(mt_o[0]), 0);
      send(1'b0); send(1'b1); send(1'b1);
      idle();
      chk("u0 overlap match", 32'(mt_o[0]), 1);
      chk("u0 overlap count", 32'(cnt_o[0]), 2);
      chk("u0 overlap window", 32'(win_o[0]), 4'b1011);

      // Clear beats bit_valid on the same edge
      send(1'b1); send(1'b0); send(1'b1);
      drive(1'b1, 1'b1, 1'b1);
      idle();
      chk("clear window", 32'(win_o[0]), 0);
      chk("clear count", 32'(cnt_o[0]), 0);
      chk("clear match", 32'(mt_o[0]), 0);
      chk("clear valid", 32'(wv_o[0]), 0);
      send(1'b0); send(1'b0); send(1'b0); send(1'b1);
      idle();
      chk("u1 0001 match", 32'(mt_o[1]), 1);
      chk("u1 0001 count", 32'(cnt_o[1]), 1);

      // Saturation of a 2-bit counter on overlapping 1111 hits
      drive(1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 8; k++) send(1'b1);
      idle();
      chk("u2 sat count", 32'(cnt_o[2]), 3);
      chk("u2 sat flag", 32'(sat_o[2]), 1);
      chk("u2 sat match", 32'(mt_o[2]), 1);

      // Async reset mid-stream, then a fresh sequence
      send(1'b1);
      async_reset();
      send(1'b0); send(1'b1); send(1'b1);
      idle();
      chk("post-reset no hit", 32'(mt_o[0]), 0);
      send(1'b1); send(1'b0); send(1'b1); send(1'b1);
      idle();
      chk("post-reset count", 32'(cnt_o[0]), 1);

      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 199) < 2) begin
            async_reset();
         end else begin
            drive(logic'($urandom_range(0, 99) < 85), logic'($urandom_range(0, 99) < 70),
                  logic'($urandom_range(0, 199) < 3));
         end
      end
      idle();
      idle();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
